shared_gf2_inv_mul_stage: RTL and testbench
===========================================

Name: shared_gf2_inv_mul_stage

Overview:
- Masked GF(2^2) stage that follows the shared X*B ^ sq-scale(X^Y) stage inside the DOM AES S-box GF(2^4) inversion.
- Consumes the shared GF(2^2) value Q from that stage and inverts it share-wise.
- Multiplies the inverse with the one-cycle-delayed X and Y shares using two DOM-indep multipliers.
- Produces the two shared GF(2^2) halves of the GF(2^4) inverse, with a valid pipeline tracking alignment.

Parameters:
- PIPELINED, 1: only value supported; DOM cross-domain terms are registered.
- SHARES, 2: number of Boolean shares (masking order + 1); must be ≥ 2.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- ValidxSI  in  1  marks X/Y (and upstream inputs) valid this cycle.
- _XxDI  in  2*SHARES  X shares, presented in the same cycle as the upstream stage's inputs.
- _YxDI  in  2*SHARES  Y shares, same timing as _XxDI.
- _QxDI  in  2*SHARES  upstream output Q shares, valid one cycle after X/Y.
- _ZxDI  in  2*SHARES*(SHARES-1)  fresh randomness, sampled in the Q cycle.
  - Low SHARES*(SHARES-1) bits go to the H multiplier; high bits go to the L multiplier.
- _HxDO  out  2*SHARES  shares of inv(Q)*Y.
- _LxDO  out  2*SHARES  shares of inv(Q)*X.
- ValidxSO  out  1  outputs valid.

Behaviour:
- Share i of any 2-bit bus occupies bits [2i+1:2i]. Random pair index p selects bits [2p+1:2p] within its half.
- Stage 0 (cycle t):
  - X, Y shares are registered into XdxDP, YdxDP.
  - ValidxSI is registered into V1.
- Stage 1 (cycle t+1):
  - Inverse is share-wise and linear: Qinv[i] = {Q[i][0], Q[i][1]} (bit swap, normal basis). No randomness is used.
  - Two DOM multipliers compute H = Qinv * Yd and L = Qinv * Xd.
  - For each multiplier, term (k,l) = gf2_mul(Qinv[k], Operand[l]), then:
    - k == l: term unchanged.
    - l > k: XOR Z[k + l*(l-1)/2].
    - l < k: XOR Z[l + k*(k-1)/2].
  - All SHARES*SHARES terms per multiplier are registered at edge t+2. V1 is registered into V2.
- Stage 2 (cycle t+2):
  - Output share k = XOR over l of the registered terms (k,l). Combinational from flops only; no input reaches the outputs combinationally.
  - ValidxSO = V2.
- Latency and throughput:
  - 2 cycles from X/Y and ValidxSI; 1 cycle from Q and Z.
  - Fully pipelined, one new input per cycle, no stalls, no backpressure.
- ValidxSI is informational only: data flops load every cycle regardless of valid.
- Reset (async assert, synchronous release):
  - Xd, Yd and all DOM flops clear to 0, so _HxDO = _LxDO = 0.
  - V1 and V2 clear to 0, so ValidxSO = 0.
  - Reset mid-stream discards in-flight items; after release, ValidxSO first asserts 2 cycles after the first ValidxSI.
- Unmasked correctness: XOR of H shares = gf2_mul(inv(XOR Q), XOR Y); same for L with X. inv(0) = 0.
- Security: no two shares of the same variable are combined before a register, apart from terms blinded by Z.

Optional Feature:
- Macro AES_DOM_OUTREG_EN.
- Defined:
  - The per-share XOR results and the valid bit are registered once more. Latency becomes 3 from X/Y and 2 from Q/Z.
  - Output registers reset to 0.
  - Stops glitch propagation of the share-recombination XOR into the next stage.
- Undefined: outputs are combinational XOR of DOM flops, as specified above.

Decomposition:
- Shared package: constants GF2_W = 2 and RAND_PAIRS(SHARES) = SHARES*(SHARES-1)/2.
- Shared package: function for the random index mapping (k,l) -> pair index, and function gf2_inv (bit swap).
- Reuse the existing gf2_mul (N=2) for the products.
- One sub-module is natural: shared_gf2_dom_mul (SHARES-generic DOM multiplier with registered terms), instantiated twice.

Test Plan:
- Reset: hold RstxBI=0 with random inputs; assert all outputs 0 and ValidxSO=0. Release; ValidxSO stays 0 until 2 cycles after ValidxSI.
- Identity: SHARES=2, Q reconstructs 2'b11 (one), Z=0, X=2'b01, Y=2'b10 → after 2 cycles, XOR of H shares = 2'b10 and XOR of L shares = 2'b01.
- Zero: Q reconstructs 2'b00 with random X, Y, Z → H and L reconstruct 2'b00.
- Exhaustive: all 16 (Q,X) and (Q,Y) unmasked pairs, random share splits and random Z, streamed back-to-back → reconstruction matches gf2_mul(inv(Q), ·) every cycle, with ValidxSO aligned.
- Randomness independence: same unmasked data with different Z/share splits → reconstructed outputs identical while individual shares differ. Repeat for SHARES=3.
- Mid-stream reset: assert RstxBI during a valid burst → outputs 0 immediately (async), no stale valid after release. With AES_DOM_OUTREG_EN defined, latency checks are shifted by +1.

Source files
------------

// File: rtl/shared_gf2_inv_mul_stage_pkg.sv
// Shared definitions for the masked GF(2^2) inversion/multiplication stage
// of the DOM AES S-box: field width, randomness bookkeeping and the
// normal-basis GF(2^2) helpers (inverse and multiply).
package shared_gf2_inv_mul_stage_pkg;

    localparam int GF2_W = 2;

    // Number of fresh random GF(2^2) values one DOM multiplier consumes.
    function automatic int rand_pairs(input int shares);
        return shares * (shares - 1) / 2;
    endfunction

    // Cross-domain term (k,l) and (l,k) share the same random value.
    function automatic int rand_idx(input int k, input int l);
        if (l > k) begin
            return k + l * (l - 1) / 2;
        end
        return l + k * (k - 1) / 2;
    endfunction

    // In the normal basis the GF(2^2) inverse equals squaring: a bit swap.
    // It is linear, so it can be applied to each share on its own.
    function automatic logic [GF2_W-1:0] gf2_inv(input logic [GF2_W-1:0] a);
        return {a[0], a[1]};
    endfunction

    // GF(2^2) multiplication in the normal basis {W^2, W}; one = 2'b11.
    function automatic logic [GF2_W-1:0] gf2_mul(input logic [GF2_W-1:0] a,
                                                 input logic [GF2_W-1:0] b);
        logic ab;
        ab = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ ab, (a[0] & b[0]) ^ ab};
    endfunction

endpackage

// File: rtl/shared_gf2_inv_mul_stage_dom_mul.sv
// SHARES-generic DOM-indep GF(2^2) multiplier. Every share product is
// registered (cross-domain products blinded with fresh randomness first);
// the output shares are the XOR of registered terms only.
module shared_gf2_dom_mul
    import shared_gf2_inv_mul_stage_pkg::*;
#(
    parameter int SHARES = 2
) (
    input  logic                                  ClkxCI,
    input  logic                                  RstxBI,
    input  logic [GF2_W*SHARES-1:0]               a_i,
    input  logic [GF2_W*SHARES-1:0]               b_i,
    input  logic [GF2_W*rand_pairs(SHARES)-1:0]   z_i,
    output logic [GF2_W*SHARES-1:0]               q_o
);

    localparam int NT = SHARES * SHARES;

    logic [NT-1:0][GF2_W-1:0] term_d;
    logic [NT-1:0][GF2_W-1:0] term_q;

    // Form all share products; blind every cross-domain product with Z.
    always_comb begin
        term_d = '0;
        for (int k = 0; k < SHARES; k++) begin
            for (int l = 0; l < SHARES; l++) begin
                term_d[k*SHARES+l] = gf2_mul(a_i[GF2_W*k +: GF2_W], b_i[GF2_W*l +: GF2_W]);
                if (k != l) begin
                    term_d[k*SHARES+l] = term_d[k*SHARES+l] ^ z_i[GF2_W*rand_idx(k, l) +: GF2_W];
                end
            end
        end
    end

    // Register every term so recombination never sees unblinded glitches.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            term_q <= '0;
        end else begin
            term_q <= term_d;
        end
    end

    // Output share k is the XOR of registered terms (k, 0..SHARES-1).
    always_comb begin
        q_o = '0;
        for (int k = 0; k < SHARES; k++) begin
            for (int l = 0; l < SHARES; l++) begin
                q_o[GF2_W*k +: GF2_W] = q_o[GF2_W*k +: GF2_W] ^ term_q[k*SHARES+l];
            end
        end
    end

endmodule

// File: rtl/shared_gf2_inv_mul_stage.sv
// Masked GF(2^2) stage of the DOM AES S-box GF(2^4) inversion: share-wise
// inverse of Q, then two DOM multiplications with the delayed X and Y shares.
// Latency 2 cycles from X/Y/valid, 1 cycle from Q/Z.
// Optional macro AES_DOM_OUTREG_EN adds one output register stage on the
// recombined shares and valid (latency 3 from X/Y, 2 from Q/Z).
module shared_gf2_inv_mul_stage
    import shared_gf2_inv_mul_stage_pkg::*;
#(
    parameter int PIPELINED = 1,
    parameter int SHARES    = 2
) (
    input  logic                              ClkxCI,
    input  logic                              RstxBI,
    input  logic                              ValidxSI,
    input  logic [GF2_W*SHARES-1:0]           _XxDI,
    input  logic [GF2_W*SHARES-1:0]           _YxDI,
    input  logic [GF2_W*SHARES-1:0]           _QxDI,
    input  logic [2*SHARES*(SHARES-1)-1:0]    _ZxDI,
    output logic [GF2_W*SHARES-1:0]           _HxDO,
    output logic [GF2_W*SHARES-1:0]           _LxDO,
    output logic                              ValidxSO
);

    localparam int ZW = GF2_W * rand_pairs(SHARES);

    // Only the registered-cross-term variant exists, with at least two shares.
    if (PIPELINED != 1 || SHARES < 2) begin : g_param_check
        $error("shared_gf2_inv_mul_stage: PIPELINED must be 1 and SHARES >= 2");
    end

    logic [GF2_W*SHARES-1:0] xd_q;
    logic [GF2_W*SHARES-1:0] yd_q;
    logic                    v1_q;
    logic                    v2_q;
    logic [GF2_W*SHARES-1:0] qinv;
    logic [GF2_W*SHARES-1:0] h_mul;
    logic [GF2_W*SHARES-1:0] l_mul;

    // Delay X, Y and valid by one cycle to line up with Q from upstream.
    // Data loads every cycle; valid only tags the pipeline slot.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            xd_q <= '0;
            yd_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            xd_q <= _XxDI;
            yd_q <= _YxDI;
            v1_q <= ValidxSI;
            v2_q <= v1_q;
        end
    end

    // Share-wise inverse of Q; linear, so no randomness is needed.
    always_comb begin
        qinv = '0;
        for (int i = 0; i < SHARES; i++) begin
            qinv[GF2_W*i +: GF2_W] = gf2_inv(_QxDI[GF2_W*i +: GF2_W]);
        end
    end

    shared_gf2_dom_mul #(
        .SHARES (SHARES)
    ) u_mul_h (
        .ClkxCI (ClkxCI),
        .RstxBI (RstxBI),
        .a_i    (qinv),
        .b_i    (yd_q),
        .z_i    (_ZxDI[ZW-1:0]),
        .q_o    (h_mul)
    );

    shared_gf2_dom_mul #(
        .SHARES (SHARES)
    ) u_mul_l (
        .ClkxCI (ClkxCI),
        .RstxBI (RstxBI),
        .a_i    (qinv),
        .b_i    (xd_q),
        .z_i    (_ZxDI[2*ZW-1:ZW]),
        .q_o    (l_mul)
    );

`ifdef AES_DOM_OUTREG_EN
    logic [GF2_W*SHARES-1:0] h_q;
    logic [GF2_W*SHARES-1:0] l_q;
    logic                    v3_q;

    // Register the recombined shares so their XOR glitches stop here.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            h_q  <= '0;
            l_q  <= '0;
            v3_q <= 1'b0;
        end else begin
            h_q  <= h_mul;
            l_q  <= l_mul;
            v3_q <= v2_q;
        end
    end

    assign _HxDO    = h_q;
    assign _LxDO    = l_q;
    assign ValidxSO = v3_q;
`else
    assign _HxDO    = h_mul;
    assign _LxDO    = l_mul;
    assign ValidxSO = v2_q;
`endif

endmodule

// File: tb/tb_shared_gf2_inv_mul_stage.sv
// Directed bench for shared_gf2_inv_mul_stage with a 2-share and a 3-share
// instance driven by the same unmasked data. Expected results come from a
// hand-computed table of inv(Q)*D in the normal-basis GF(2^2).
module tb_shared_gf2_inv_mul_stage;

`ifdef AES_DOM_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        valid_i = 1'b0;
    logic [3:0]  x2 = '0, y2 = '0, q2 = '0, z2 = '0;
    logic [3:0]  h2, l2;
    logic        v2o;
    logic [5:0]  x3 = '0, y3 = '0, q3 = '0;
    logic [11:0] z3 = '0;
    logic [5:0]  h3, l3;
    logic        v3o;

    int total = 0;
    int bad = 0;

    // ref_tbl[{q, d}] = inv(q) * d, worked out by hand.
    logic [1:0] ref_tbl [16];

    int         n_items = 0;
    logic [1:0] it_q [64];
    logic [1:0] it_x [64];
    logic [1:0] it_y [64];
    logic       it_v [64];

    shared_gf2_inv_mul_stage #(.PIPELINED(1), .SHARES(2)) u_dut2 (
        .ClkxCI (clk), .RstxBI (rst_n), .ValidxSI (valid_i),
        ._XxDI (x2), ._YxDI (y2), ._QxDI (q2), ._ZxDI (z2),
        ._HxDO (h2), ._LxDO (l2), .ValidxSO (v2o)
    );

    shared_gf2_inv_mul_stage #(.PIPELINED(1), .SHARES(3)) u_dut3 (
        .ClkxCI (clk), .RstxBI (rst_n), .ValidxSI (valid_i),
        ._XxDI (x3), ._YxDI (y3), ._QxDI (q3), ._ZxDI (z3),
        ._HxDO (h3), ._LxDO (l3), .ValidxSO (v3o)
    );

    function automatic logic [3:0] split2(input logic [1:0] v, input logic [1:0] m);
        return {m, v ^ m};
    endfunction

    function automatic logic [5:0] split3(input logic [1:0] v, input logic [1:0] m1,
                                          input logic [1:0] m2);
        return {m2, m1, v ^ m1 ^ m2};
    endfunction

    function automatic logic [1:0] recon2(input logic [3:0] s);
        return s[1:0] ^ s[3:2];
    endfunction

    function automatic logic [1:0] recon3(input logic [5:0] s);
        return s[1:0] ^ s[3:2] ^ s[5:4];
    endfunction

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(0, 3));
    endfunction

    // Cycle j: X/Y of item j, Q/Z of item j-1.
    // mode 0: zero masks, Z=0; 1: zero masks, fixed Z; 2: random all; 3: random masks, Z=0.
    task automatic drive_cycle(input int j, input int mode);
        logic [1:0] r [6];
        logic [1:0] dx, dy, dq;
        for (int k = 0; k < 6; k++) r[k] = (mode >= 2) ? rnd2() : 2'b00;
        if (j < n_items) begin
            valid_i = it_v[j];
            dx = it_x[j];
            dy = it_y[j];
        end else begin
            valid_i = 1'b0;
            dx = rnd2();
            dy = rnd2();
        end
        x2 = split2(dx, r[0]);
        y2 = split2(dy, r[1]);
        x3 = split3(dx, r[2], r[3]);
        y3 = split3(dy, r[4], r[5]);
        for (int k = 0; k < 6; k++) r[k] = (mode >= 2) ? rnd2() : 2'b00;
        if (j >= 1 && j <= n_items) dq = it_q[j-1];
        else dq = rnd2();
        q2 = split2(dq, r[0]);
        q3 = split3(dq, r[1], r[2]);
        case (mode)
            1:       begin z2 = 4'b0101; z3 = 12'b000110_000110; end
            2:       begin z2 = 4'($urandom); z3 = 12'($urandom); end
            default: begin z2 = '0; z3 = '0; end
        endcase
    endtask

    // Stream all items back-to-back and check every output slot.
    task automatic run_stream(input int mode, input string name);
        int i;
        logic [1:0] eh, el, es;
        for (int j = 0; j < n_items + LAT; j++) begin
            @(posedge clk); #1;
            drive_cycle(j, mode);
            @(negedge clk);
            if (j >= LAT) begin
                i  = j - LAT;
                eh = ref_tbl[{it_q[i], it_y[i]}];
                el = ref_tbl[{it_q[i], it_x[i]}];
                total++;
                if (recon2(h2) !== eh) begin
                    bad++;
                    $display("FAIL %s h2 item %0d: got %b expected %b", name, i, recon2(h2), eh);
                end
                total++;
                if (recon2(l2) !== el) begin
                    bad++;
                    $display("FAIL %s l2 item %0d: got %b expected %b", name, i, recon2(l2), el);
                end
                total++;
                if (recon3(h3) !== eh) begin
                    bad++;
                    $display("FAIL %s h3 item %0d: got %b expected %b", name, i, recon3(h3), eh);
                end
                total++;
                if (recon3(l3) !== el) begin
                    bad++;
                    $display("FAIL %s l3 item %0d: got %b expected %b", name, i, recon3(l3), el);
                end
                total++;
                if (v2o !== it_v[i] || v3o !== it_v[i]) begin
                    bad++;
                    $display("FAIL %s valid item %0d: got %b/%b expected %b", name, i, v2o, v3o, it_v[i]);
                end
                if (mode <= 1) begin
                    es = (mode == 1) ? 2'b01 : 2'b00;
                    total++;
                    if (h2[3:2] !== es || l2[3:2] !== es || h3[5:4] !== es || l3[5:4] !== es) begin
                        bad++;
                        $display("FAIL %s last_share item %0d: got %b %b %b %b expected %b",
                                 name, i, h2[3:2], l2[3:2], h3[5:4], l3[5:4], es);
                    end
                end
            end else begin
                total++;
                if (v2o !== 1'b0 || v3o !== 1'b0) begin
                    bad++;
                    $display("FAIL %s early_valid cycle %0d: got %b/%b expected 0", name, j, v2o, v3o);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            valid_i = 1'b1;
            x2 = 4'($urandom); y2 = 4'($urandom); q2 = 4'($urandom); z2 = 4'($urandom);
            x3 = 6'($urandom); y3 = 6'($urandom); q3 = 6'($urandom); z3 = 12'($urandom);
            @(negedge clk);
            total++;
            if (h2 !== 4'b0 || l2 !== 4'b0 || v2o !== 1'b0 ||
                h3 !== 6'b0 || l3 !== 6'b0 || v3o !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: got %h %h %b %h %h %b expected all 0", h2, l2, v2o, h3, l3, v3o);
            end
        end
        valid_i = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            @(negedge clk);
            total++;
            if (v2o !== 1'b0 || v3o !== 1'b0) begin
                bad++;
                $display("FAIL reset_release_valid: got %b/%b expected 0", v2o, v3o);
            end
        end
    endtask

    task automatic test_identity();
        n_items = 1;
        it_q[0] = 2'b11; it_x[0] = 2'b01; it_y[0] = 2'b10; it_v[0] = 1'b1;
        run_stream(3, "identity");
    endtask

    task automatic test_zero();
        n_items = 6;
        for (int i = 0; i < 6; i++) begin
            it_q[i] = 2'b00; it_x[i] = rnd2(); it_y[i] = rnd2(); it_v[i] = 1'b1;
        end
        run_stream(2, "zero");
    endtask

    task automatic test_exhaustive();
        logic [3:0] idx;
        n_items = 16;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            it_q[i] = idx[3:2]; it_x[i] = idx[1:0]; it_y[i] = ~idx[1:0]; it_v[i] = 1'b1;
        end
        run_stream(2, "exhaustive");
    endtask

    task automatic test_back_to_back();
        n_items = 24;
        for (int i = 0; i < 24; i++) begin
            it_q[i] = rnd2(); it_x[i] = rnd2(); it_y[i] = rnd2();
            it_v[i] = 1'($urandom_range(0, 1));
        end
        run_stream(2, "back_to_back");
    endtask

    task automatic test_rand_indep();
        n_items = 8;
        for (int i = 0; i < 8; i++) begin
            it_q[i] = rnd2(); it_x[i] = rnd2(); it_y[i] = rnd2(); it_v[i] = 1'b1;
        end
        run_stream(0, "indep_plain");
        run_stream(1, "indep_fixed_z");
        run_stream(2, "indep_random");
    endtask

    task automatic test_midstream_reset();
        n_items = 6;
        for (int i = 0; i < 6; i++) begin
            it_q[i] = 2'b11; it_x[i] = rnd2(); it_y[i] = rnd2(); it_v[i] = 1'b1;
        end
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            drive_cycle(j, 2);
        end
        @(negedge clk);
        total++;
        if (v2o !== 1'b1 || v3o !== 1'b1) begin
            bad++;
            $display("FAIL midreset_live_valid: got %b/%b expected 1", v2o, v3o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (h2 !== 4'b0 || l2 !== 4'b0 || v2o !== 1'b0 ||
            h3 !== 6'b0 || l3 !== 6'b0 || v3o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: got %h %h %b %h %h %b expected all 0", h2, l2, v2o, h3, l3, v3o);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_items = 0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            drive_cycle(j, 2);
            @(negedge clk);
            total++;
            if (v2o !== 1'b0 || v3o !== 1'b0) begin
                bad++;
                $display("FAIL midreset_stale_valid cycle %0d: got %b/%b expected 0", j, v2o, v3o);
            end
        end
        n_items = 1;
        it_q[0] = 2'b10; it_x[0] = 2'b10; it_y[0] = 2'b01; it_v[0] = 1'b1;
        run_stream(2, "after_reset");
    endtask

    initial begin
        ref_tbl = '{2'b00, 2'b00, 2'b00, 2'b00,
                    2'b00, 2'b11, 2'b01, 2'b10,
                    2'b00, 2'b10, 2'b11, 2'b01,
                    2'b00, 2'b01, 2'b10, 2'b11};
        #1;
        test_reset();
        test_identity();
        test_zero();
        test_exhaustive();
        test_back_to_back();
        test_rand_indep();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
